// File: rtl/pipeline_pkg.sv
// Shared pipeline types: stage occupancy states, the default bubble control
// value, and packed views of the stage buses carried through elastic_stage_reg.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam logic [7:0] CTRL_BUBBLE_DEFAULT = 8'h00;

    // A bubble must decode to all-zero enables, so every strobe is active-high.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic [3:0] alu_op;
    } stage_ctrl_t;

    typedef struct packed {
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [5:0]  opcode;
    } stage_data_t;

    localparam int STAGE_CTRL_W = $bits(stage_ctrl_t);
    localparam int STAGE_DATA_W = $bits(stage_data_t);

endpackage

// File: rtl/elastic_stage_reg.sv
// Valid/ready pipeline stage register with flush, masked control output, an
// optional two-entry skid buffer and a saturating back-pressure counter.
module elastic_stage_reg
    import pipeline_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
    parameter int                 SKID        = 1,
    parameter int                 CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clear
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    generate
        if (SKID != 0) begin : g_skid
            stage_state_t      state_q, state_d;
            logic [DATA_W-1:0] skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
            logic              in_ready_q, in_ready_d;
            logic              up, dn;

            always_comb begin
                state_d     = state_q;
                data_d      = data_q;
                ctrl_d      = ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                up          = in_valid && in_ready_q;
                dn          = (state_q != EMPTY) && out_ready;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    unique case (state_q)
                        EMPTY: begin
                            if (up) begin
                                data_d  = in_data;
                                ctrl_d  = in_ctrl;
                                state_d = BUSY;
                            end
                        end
                        BUSY: begin
                            if (up && dn) begin
                                data_d = in_data;
                                ctrl_d = in_ctrl;
                            end else if (up) begin
                                skid_data_d = in_data;
                                skid_ctrl_d = in_ctrl;
                                state_d     = FULL;
                            end else if (dn) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            if (dn) begin
                                data_d  = skid_data_q;
                                ctrl_d  = skid_ctrl_q;
                                state_d = BUSY;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
                // in_ready is registered so out_ready never reaches it combinationally.
                in_ready_d = (state_d != FULL);
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_q     <= EMPTY;
                    data_q      <= '0;
                    ctrl_q      <= CTRL_BUBBLE;
                    skid_data_q <= '0;
                    skid_ctrl_q <= CTRL_BUBBLE;
                    in_ready_q  <= 1'b1;
                end else begin
                    state_q     <= state_d;
                    data_q      <= data_d;
                    ctrl_q      <= ctrl_d;
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    in_ready_q  <= in_ready_d;
                end
            end

            assign valid    = (state_q != EMPTY);
            assign in_ready = in_ready_q;
        end else begin : g_single
            logic valid_q, valid_d;
            logic up, dn;

            assign in_ready = !valid_q || out_ready;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                ctrl_d  = ctrl_q;
                up      = in_valid && in_ready;
                dn      = valid_q && out_ready;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (up) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                    ctrl_d  = in_ctrl;
                end else if (dn) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= CTRL_BUBBLE;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    ctrl_q  <= ctrl_d;
                end
            end

            assign valid = valid_q;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = valid;
    assign out_data  = data_q;
    assign out_ctrl  = valid ? ctrl_q : CTRL_BUBBLE;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Bench for elastic_stage_reg: one SKID=1 instance and one SKID=0/CNT_W=4
// instance, driven by directed sequences, a vector table and random traffic.
module tb_elastic_stage_reg;

    logic clock;
    logic reset;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clear;
    logic [31:0] s_in_data, s_out_data;
    logic [7:0]  s_in_ctrl, s_out_ctrl;
    logic [15:0] s_stall_cnt;

    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cnt_clear;
    logic [31:0] n_in_data, n_out_data;
    logic [7:0]  n_in_ctrl, n_out_ctrl;
    logic [3:0]  n_stall_cnt;

    localparam logic [7:0] S_BUBBLE = 8'hA5;
    localparam logic [7:0] N_BUBBLE = 8'h5A;

    int checks = 0;
    int errors = 0;

    elastic_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(S_BUBBLE), .SKID(1), .CNT_W(16)
    ) u_skid (
        .clock(clock), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_ctrl(s_in_ctrl),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt), .cnt_clear(s_cnt_clear)
    );

    elastic_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(N_BUBBLE), .SKID(0), .CNT_W(4)
    ) u_single (
        .clock(clock), .reset(reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .in_ctrl(n_in_ctrl),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .stall_cnt(n_stall_cnt), .cnt_clear(n_cnt_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic [7:0]  in_ctrl;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [7:0]  exp_out_ctrl;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    vec_t vecs[7];
    ent_t qs[$];
    ent_t qn[$];
    int unsigned cs, cn;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_flush = 0; s_in_valid = 0; s_in_data = '0; s_in_ctrl = '0; s_out_ready = 0; s_cnt_clear = 0;
        n_flush = 0; n_in_valid = 0; n_in_data = '0; n_in_ctrl = '0; n_out_ready = 0; n_cnt_clear = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input int i);
        n_flush     = vecs[i].flush;
        n_in_valid  = vecs[i].in_valid;
        n_in_data   = vecs[i].in_data;
        n_in_ctrl   = vecs[i].in_ctrl;
        n_out_ready = vecs[i].out_ready;
    endtask

    task automatic check_row(input int i);
        check_bit ("tbl_out_valid", n_out_valid, vecs[i].exp_out_valid);
        check_word("tbl_out_data",  n_out_data,  vecs[i].exp_out_data);
        check_word("tbl_out_ctrl",  32'(n_out_ctrl), 32'(vecs[i].exp_out_ctrl));
    endtask

    task automatic check_models();
        check_bit("rnd_s_valid", s_out_valid, qs.size() > 0);
        check_bit("rnd_s_ready", s_in_ready, qs.size() < 2);
        if (qs.size() > 0) begin
            check_word("rnd_s_data", s_out_data, qs[0].d);
            check_word("rnd_s_ctrl", 32'(s_out_ctrl), 32'(qs[0].c));
        end else begin
            check_word("rnd_s_bubble", 32'(s_out_ctrl), 32'(S_BUBBLE));
        end
        check_word("rnd_s_cnt", 32'(s_stall_cnt), cs);
        check_bit("rnd_n_valid", n_out_valid, qn.size() > 0);
        if (qn.size() > 0) begin
            check_word("rnd_n_data", n_out_data, qn[0].d);
            check_word("rnd_n_ctrl", 32'(n_out_ctrl), 32'(qn[0].c));
        end else begin
            check_word("rnd_n_bubble", 32'(n_out_ctrl), 32'(N_BUBBLE));
        end
        check_word("rnd_n_cnt", 32'(n_stall_cnt), cn);
    endtask

    // Queue model: an entry joins on acceptance and leaves on consumption.
    task automatic update_models();
        logic up, dn, stall;
        up    = s_in_valid && (qs.size() < 2);
        dn    = (qs.size() > 0) && s_out_ready;
        stall = (qs.size() > 0) && !s_out_ready;
        if (s_cnt_clear) cs = 0;
        else if (stall && cs != 65535) cs++;
        if (s_flush) qs.delete();
        else begin
            if (dn) void'(qs.pop_front());
            if (up) qs.push_back('{d: s_in_data, c: s_in_ctrl});
        end
        up    = n_in_valid && ((qn.size() == 0) || n_out_ready);
        dn    = (qn.size() > 0) && n_out_ready;
        stall = (qn.size() > 0) && !n_out_ready;
        if (n_cnt_clear) cn = 0;
        else if (stall && cn != 15) cn++;
        if (n_flush) qn.delete();
        else begin
            if (dn) void'(qn.pop_front());
            if (up) qn.push_back('{d: n_in_data, c: n_in_ctrl});
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h100, 8'h11, 1'b0, 1'b1, 1'b1, 32'h100, 8'h11};
        vecs[1] = '{1'b0, 1'b1, 32'h101, 8'h22, 1'b0, 1'b0, 1'b1, 32'h100, 8'h11};
        vecs[2] = '{1'b0, 1'b1, 32'h101, 8'h22, 1'b1, 1'b1, 1'b1, 32'h101, 8'h22};
        vecs[3] = '{1'b0, 1'b0, 32'h000, 8'h00, 1'b1, 1'b1, 1'b0, 32'h101, N_BUBBLE};
        vecs[4] = '{1'b0, 1'b1, 32'h102, 8'h33, 1'b0, 1'b1, 1'b1, 32'h102, 8'h33};
        vecs[5] = '{1'b1, 1'b1, 32'h103, 8'h44, 1'b1, 1'b1, 1'b0, 32'h102, N_BUBBLE};
        vecs[6] = '{1'b0, 1'b0, 32'h000, 8'h00, 1'b0, 1'b1, 1'b0, 32'h102, N_BUBBLE};

        idle_inputs();
        do_reset();
        #1;
        check_bit ("rst_s_valid", s_out_valid, 1'b0);
        check_bit ("rst_s_ready", s_in_ready, 1'b1);
        check_word("rst_s_ctrl",  32'(s_out_ctrl), 32'(S_BUBBLE));
        check_word("rst_s_data",  s_out_data, 32'h0);
        check_word("rst_s_cnt",   32'(s_stall_cnt), 32'h0);
        check_bit ("rst_n_valid", n_out_valid, 1'b0);
        check_word("rst_n_ctrl",  32'(n_out_ctrl), 32'(N_BUBBLE));

        // Streaming: each entry visible one cycle after acceptance, no gaps.
        s_out_ready = 1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            if (i > 0) begin
                check_bit ("stream_valid", s_out_valid, 1'b1);
                check_word("stream_data",  s_out_data, 32'h10 + 32'(i - 1));
                check_word("stream_ctrl",  32'(s_out_ctrl), 32'(i));
                check_bit ("stream_ready", s_in_ready, 1'b1);
            end
            if (i < 8) begin
                s_in_valid = 1; s_in_data = 32'h10 + 32'(i); s_in_ctrl = 8'(i + 1);
            end else begin
                s_in_valid = 0;
            end
        end
        @(negedge clock);
        check_bit("stream_drained", s_out_valid, 1'b0);

        // Back-pressure through the skid register.
        s_out_ready = 0; s_cnt_clear = 1;
        s_in_valid = 1; s_in_data = 32'hA; s_in_ctrl = 8'h0A;
        @(negedge clock);
        s_cnt_clear = 0;
        check_bit ("bp_ready_a", s_in_ready, 1'b1);
        check_word("bp_data_a",  s_out_data, 32'hA);
        s_in_data = 32'hB; s_in_ctrl = 8'h0B;
        @(negedge clock);
        check_bit ("bp_ready_fall", s_in_ready, 1'b0);
        check_word("bp_cnt1", 32'(s_stall_cnt), 32'd1);
        s_in_data = 32'hC; s_in_ctrl = 8'h0C;
        @(negedge clock);
        check_bit ("bp_ready_held", s_in_ready, 1'b0);
        check_word("bp_hold_a", s_out_data, 32'hA);
        @(negedge clock);
        check_word("bp_cnt3", 32'(s_stall_cnt), 32'd3);
        check_word("bp_out_a", s_out_data, 32'hA);
        s_out_ready = 1;
        @(negedge clock);
        check_word("bp_out_b", s_out_data, 32'hB);
        check_bit ("bp_ready_back", s_in_ready, 1'b1);
        check_word("bp_cnt_kept", 32'(s_stall_cnt), 32'd3);
        @(negedge clock);
        check_word("bp_out_c", s_out_data, 32'hC);
        check_bit ("bp_valid_c", s_out_valid, 1'b1);
        s_in_valid = 0;
        @(negedge clock);
        check_bit("bp_drained", s_out_valid, 1'b0);

        // Flush while FULL with an incoming entry.
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h1; s_in_ctrl = 8'h01;
        @(negedge clock);
        s_in_data = 32'h2; s_in_ctrl = 8'h02;
        @(negedge clock);
        check_bit("fl_full", s_in_ready, 1'b0);
        s_flush = 1; s_in_data = 32'hEE; s_in_ctrl = 8'hEE;
        @(negedge clock);
        check_bit ("fl_valid", s_out_valid, 1'b0);
        check_word("fl_ctrl",  32'(s_out_ctrl), 32'(S_BUBBLE));
        check_bit ("fl_ready", s_in_ready, 1'b1);
        check_word("fl_cnt_kept", 32'(s_stall_cnt), 32'd5);
        s_flush = 0; s_in_valid = 0; s_out_ready = 1;
        repeat (3) begin
            @(negedge clock);
            check_bit("fl_no_ghost", s_out_valid, 1'b0);
        end

        // SKID=0 vector table, including same-cycle in_ready from out_ready.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i > 0) check_row(i - 1);
            apply_stimulus(i);
            #1;
            check_bit("tbl_in_ready", n_in_ready, vecs[i].exp_in_ready);
        end
        @(negedge clock);
        check_row(6);

        // Counter saturation and clear-over-increment on the 4-bit counter.
        n_flush = 0; n_in_valid = 1; n_in_data = 32'h55; n_in_ctrl = 8'h55;
        n_out_ready = 0; n_cnt_clear = 1;
        @(negedge clock);
        n_in_valid = 0; n_cnt_clear = 0;
        check_word("cnt_cleared", 32'(n_stall_cnt), 32'd0);
        repeat (14) @(posedge clock);
        @(negedge clock);
        check_word("cnt_14", 32'(n_stall_cnt), 32'd14);
        repeat (6) @(posedge clock);
        @(negedge clock);
        check_word("cnt_sat", 32'(n_stall_cnt), 32'd15);
        n_cnt_clear = 1;
        @(negedge clock);
        check_word("cnt_clr_prio", 32'(n_stall_cnt), 32'd0);
        n_cnt_clear = 0;
        @(negedge clock);
        check_word("cnt_resume", 32'(n_stall_cnt), 32'd1);
        n_out_ready = 1;
        @(negedge clock);

        // Random traffic against the queue model.
        idle_inputs();
        do_reset();
        qs.delete(); qn.delete(); cs = 0; cn = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clock);
            check_models();
            s_flush     = ($urandom_range(15) == 0);
            s_cnt_clear = ($urandom_range(31) == 0);
            s_in_valid  = ($urandom_range(9) < 7);
            s_out_ready = ($urandom_range(9) < 6);
            s_in_data   = $urandom;
            s_in_ctrl   = 8'($urandom);
            n_flush     = ($urandom_range(15) == 0);
            n_cnt_clear = ($urandom_range(31) == 0);
            n_in_valid  = ($urandom_range(9) < 7);
            n_out_ready = ($urandom_range(9) < 5);
            n_in_data   = $urandom;
            n_in_ctrl   = 8'($urandom);
            #1;
            check_bit("rnd_n_ready", n_in_ready, (qn.size() == 0) || n_out_ready);
            update_models();
        end

        // Asynchronous reset mid-operation, then resume.
        @(negedge clock);
        idle_inputs();
        s_in_valid = 1; s_in_data = 32'h66; s_in_ctrl = 8'h66;
        repeat (2) @(negedge clock);
        s_in_valid = 0;
        check_bit("arst_pre_valid", s_out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit ("arst_valid", s_out_valid, 1'b0);
        check_word("arst_ctrl",  32'(s_out_ctrl), 32'(S_BUBBLE));
        check_word("arst_data",  s_out_data, 32'h0);
        check_bit ("arst_ready", s_in_ready, 1'b1);
        check_word("arst_cnt",   32'(s_stall_cnt), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        s_in_valid = 1; s_in_data = 32'h77; s_in_ctrl = 8'h77; s_out_ready = 1;
        @(negedge clock);
        s_in_valid = 0;
        check_bit ("resume_valid", s_out_valid, 1'b1);
        check_word("resume_data",  s_out_data, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
